// File: rtl/fifo_slave_if.sv
// rtl/fifo_slave_if.sv - bus-side signal bundle between the single bus master and fifo_slave
//
// Signals:
//   S_sel   master->slave  slave select from the bus decoder
//   S_wr    master->slave  1 = write access, 0 = read access
//   S_addr  master->slave  byte-free register address, only [2:0] decoded by the slave
//   S_din   master->slave  write data
//   S_dout  slave->master  registered read data
interface fifo_slave_if;
    logic        S_sel;
    logic        S_wr;
    logic [7:0]  S_addr;
    logic [31:0] S_din;
    logic [31:0] S_dout;

    modport master (
        output S_sel,
        output S_wr,
        output S_addr,
        output S_din,
        input  S_dout
    );

    modport slave (
        input  S_sel,
        input  S_wr,
        input  S_addr,
        input  S_din,
        output S_dout
    );
endinterface

// File: rtl/fifo_slave.sv
// rtl/fifo_slave.sv - memory-mapped 32-bit FIFO slave with sticky error flags
//
// Ports:
//   clk      system clock, all state on rising edge
//   reset_n  synchronous active-low reset
//   bus      fifo_slave_if.slave: S_sel/S_wr/S_addr/S_din in, S_dout out (registered)
//   irq      threshold interrupt, registered (only when FIFO_IRQ_EN is defined)
//
// Register map (S_addr[2:0]):
//   0 DATA_IN  W: push S_din            R: 0
//   1 DATA_OUT R: pop head into S_dout  W: ignored
//   2 STATUS   R: {count[15:8], ovf[3], unf[2], full[1], empty[0]}
//   3 CTRL     W: bit0 flush, bit1 clear sticky flags   R: 0
//   4 THRESH   RW bits[7:0] with FIFO_IRQ_EN, otherwise reads 0
//   5-7        read 0, writes ignored
//
// Optional feature macro: FIFO_IRQ_EN (threshold register and irq output).
module fifo_slave #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    fifo_slave_if.slave   bus
`ifdef FIFO_IRQ_EN
    ,
    output logic          irq
`endif
);

    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] FULL_CNT = CW'(1) << DEPTH_LOG2;

    logic [31:0]           r_mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_unf;
    logic                  r_ovf;
    logic [31:0]           r_dout;

    logic [2:0]    w_off;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_clear;
    logic [CW-1:0] w_count_next;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;
    logic          w_unused_addr;

    assign w_off         = bus.S_addr[2:0];
    assign w_unused_addr = ^bus.S_addr[7:3];
    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == FULL_CNT);
    assign w_push        = bus.S_sel &  bus.S_wr & (w_off == 3'd0);
    assign w_pop         = bus.S_sel & ~bus.S_wr & (w_off == 3'd1);
    assign w_flush       = bus.S_sel &  bus.S_wr & (w_off == 3'd3) & bus.S_din[0];
    assign w_clear       = bus.S_sel &  bus.S_wr & (w_off == 3'd3) & bus.S_din[1];
    assign w_status      = {16'h0, 8'(r_count), 4'h0, r_ovf, r_unf, w_full, w_empty};
    assign bus.S_dout    = r_dout;

`ifdef FIFO_IRQ_EN
    logic [7:0] r_thresh;
    logic       r_irq;
    logic [7:0] w_thresh_next;
    logic       w_thresh_wr;

    assign w_thresh_wr   = bus.S_sel & bus.S_wr & (w_off == 3'd4);
    assign w_thresh_next = w_thresh_wr ? bus.S_din[7:0] : r_thresh;
    assign irq           = r_irq;
`endif

    // Occupancy after this edge; at most one of push/pop/flush per cycle.
    always_comb begin
        w_count_next = r_count;
        if (w_flush)
            w_count_next = '0;
        else if (w_push && !w_full)
            w_count_next = r_count + 1'b1;
        else if (w_pop && !w_empty)
            w_count_next = r_count - 1'b1;
    end

    // Read mux; every non-read cycle returns 0, as does an underflowing pop.
    always_comb begin
        w_rdata = 32'h0;
        if (bus.S_sel && !bus.S_wr) begin
            case (w_off)
                3'd1:    w_rdata = w_empty ? 32'h0 : r_mem[r_rptr];
                3'd2:    w_rdata = w_status;
`ifdef FIFO_IRQ_EN
                3'd4:    w_rdata = {24'h0, r_thresh};
`endif
                default: w_rdata = 32'h0;
            endcase
        end
    end

    // Storage array deliberately has no reset.
    always_ff @(posedge clk) begin
        if (reset_n && w_push && !w_full)
            r_mem[r_wptr] <= bus.S_din;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_unf   <= 1'b0;
            r_ovf   <= 1'b0;
            r_dout  <= 32'h0;
        end else begin
            r_count <= w_count_next;
            r_dout  <= w_rdata;
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push && !w_full)
                    r_wptr <= r_wptr + 1'b1;
                if (w_pop && !w_empty)
                    r_rptr <= r_rptr + 1'b1;
            end
            if (w_clear) begin
                r_unf <= 1'b0;
                r_ovf <= 1'b0;
            end else begin
                if (w_push && w_full)
                    r_ovf <= 1'b1;
                if (w_pop && w_empty)
                    r_unf <= 1'b1;
            end
        end
    end

`ifdef FIFO_IRQ_EN
    // irq tracks the post-edge occupancy against the post-edge threshold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_thresh <= 8'h0;
            r_irq    <= 1'b0;
        end else begin
            r_thresh <= w_thresh_next;
            r_irq    <= (w_thresh_next != 8'h0) && (8'(w_count_next) >= w_thresh_next);
        end
    end
`endif

endmodule

// File: doc/fifo_slave.md
# fifo_slave

Memory-mapped 32-bit FIFO peripheral attached as a slave on the single-master bus, directly downstream of the bus decoder's slave-select/address/data outputs. The master pushes words by writing a data register and pops them by reading another; status and control registers expose occupancy and sticky error flags. Read data is registered and returned on `S_dout` for the bus read-data mux.

## Interface
- `DEPTH_LOG2`, default 3: FIFO depth = 2^DEPTH_LOG2 words; legal range 1..7.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `S_sel`  in  1  slave select from bus decoder; access occurs only when 1.
- `S_wr`  in  1  1 = write access, 0 = read access.
- `S_addr`  in  8  bus address; only `S_addr[2:0]` decoded, upper bits ignored.
- `S_din`  in  32  write data from bus.
- `S_dout`  out  32  registered read data to bus.
- `irq`  out  1  threshold interrupt; present only with `FIFO_IRQ_EN`.

## Operation
- Register map (offset = `S_addr[2:0]`):
  - 0 DATA_IN: write pushes `S_din`; read returns 0, no side effect.
  - 1 DATA_OUT: read pops head word into `S_dout`; write ignored.
  - 2 STATUS (RO): bit0 empty, bit1 full, bit2 underflow (sticky), bit3 overflow (sticky), bits[15:8] count zero-extended, other bits 0.
  - 3 CTRL (WO, reads 0): bit0 = 1 flushes FIFO (pointers and count to 0, data not cleared); bit1 = 1 clears both sticky flags; both bits may be set together.
  - 4 THRESH: see Configuration. Offsets 5-7: read 0, writes ignored.
- Storage: 2^DEPTH_LOG2 x 32 array, write pointer, read pointer (DEPTH_LOG2 bits, wrap modulo depth), count (DEPTH_LOG2+1 bits). empty = (count==0), full = (count==2^DEPTH_LOG2).
- Push when full: word dropped, pointers/count unchanged, overflow set.
- Pop when empty: `S_dout` loads 0, pointers unchanged, underflow set.
- Every cycle with `S_sel`=1 is one independent access; a master holding a DATA_OUT read for N cycles pops N words.
- Only one access per cycle exists, so push/pop/flush never coincide.
- Storage contents are not reset; only pointers, count, flags, `S_dout`, threshold.

## Timing
- Reset (`reset_n`=0 at a rising edge): pointers 0, count 0, flags 0, `S_dout`=0, `irq`=0, THRESH=0. Reset mid-operation discards FIFO contents in that same edge.
- Writes: state updated at the rising edge ending the access cycle; STATUS reflects it from the next cycle.
- Reads: `S_dout` loads the addressed value at the rising edge ending the access cycle; 1-cycle read latency. STATUS read returns pre-access state.
- Cycles with no read access (`S_sel`=0 or `S_wr`=1): `S_dout` loads 0 at the edge.
- Back-to-back pops return consecutive words on consecutive cycles.

## Configuration
- `FIFO_IRQ_EN` defined: offset 4 THRESH is RW, bits[7:0] stored (upper bits ignored/read 0); `irq` port exists and is registered: `irq`=1 the cycle after any edge where next count >= THRESH and THRESH != 0, else 0.
- `FIFO_IRQ_EN` undefined: no `irq` port, no threshold register; offset 4 reads 0, writes ignored.

## Test plan
- Reset then read STATUS -> `S_dout` = 0x00000001 one cycle later (empty, count 0).
- Push 0x11, 0x22, 0x33 to offset 0, then three consecutive reads of offset 1 -> `S_dout` = 0x11, 0x22, 0x33 on successive cycles; STATUS then 0x00000001.
- Push 9 words 0x100..0x108 with DEPTH_LOG2=3 -> STATUS = 0x0000080A (count 8, full, overflow); eight pops return 0x100..0x107; 0x108 lost.
- Pop when empty -> `S_dout`=0, STATUS = 0x00000005; write CTRL=0x2 -> STATUS = 0x00000001.
- Push 0x5 and 0x6 to offset 0, write CTRL=0x1 -> STATUS = 0x00000001; pushes after flush pop in order from new data; pointer wrap verified by 20 push/pop pairs returning matching data.
- With `FIFO_IRQ_EN`: THRESH=3, push 3 words -> `irq` rises the cycle after third push; one pop -> `irq` falls the cycle after; assert `reset_n`=0 mid-stream -> `irq`=0, STATUS 0x00000001.
